// File: rtl/rf_pkg.sv
// rf_pkg: shared constants and byte-merge helper for the multi-port register file
package rf_pkg;
  localparam int RF_BYTE = 8;
  function automatic logic [RF_BYTE-1:0] byte_sel(input logic [RF_BYTE-1:0] old_b,
                                                  input logic [RF_BYTE-1:0] new_b,
                                                  input logic en);
    return en ? new_b : old_b;
  endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending-write busy bits, set on issue and cleared on writeback
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG),
  parameter int NRD  = 2,
  parameter int NWR  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  output logic              any_busy
);
  logic [NREG-1:0] busy, busy_nxt;
  always_comb begin
    busy_nxt = busy;
    for (int a = 1; a < NREG; a++) begin
      for (int p = 0; p < NWR; p++)
        if (wr_en[p] && wr_addr[p*AW +: AW] == AW'(a)) busy_nxt[a] = 1'b0;
      // a new issue outranks a writeback from the previous producer
      if (iss_en && iss_addr == AW'(a)) busy_nxt[a] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk)
    busy <= rst ? '0 : busy_nxt;
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    assign rd_busy[i] = busy[rd_addr[i*AW +: AW]];
  end
  assign any_busy = |busy;
endmodule

// File: rtl/rf_multiport.sv
// rf_multiport: multi-port register file with byte enables, write-to-read bypass and busy scoreboard
module rf_multiport
  import rf_pkg::*;
#(
  parameter int DW   = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG),
  parameter int NRD  = 2,
  parameter int NWR  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NRD*AW-1:0]        rd_addr,
  output logic [NRD*DW-1:0]        rd_data,
  output logic [NRD-1:0]           rd_busy,
  input  logic [NWR-1:0]           wr_en,
  input  logic [NWR*AW-1:0]        wr_addr,
  input  logic [NWR*DW/RF_BYTE-1:0] wr_be,
  input  logic [NWR*DW-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [AW-1:0]            iss_addr,
  output logic                     any_busy
);
  localparam int NB = DW / RF_BYTE;
  logic [DW-1:0] regs [NREG];
  logic [DW-1:0] nxt [NREG];
  // nxt holds every register's post-write value; it feeds both storage and the bypassed reads
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      nxt[r] = regs[r];
      for (int p = 0; p < NWR; p++)
        for (int b = 0; b < NB; b++)
          if (wr_en[p] && wr_addr[p*AW +: AW] == AW'(r))
            nxt[r][b*RF_BYTE +: RF_BYTE] = byte_sel(nxt[r][b*RF_BYTE +: RF_BYTE],
                                                    wr_data[p*DW + b*RF_BYTE +: RF_BYTE],
                                                    wr_be[p*NB + b]);
    end
    nxt[0] = '0;
  end
  always_ff @(posedge clk)
    for (int r = 0; r < NREG; r++)
      regs[r] <= rst ? '0 : nxt[r];
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    assign rd_data[i*DW +: DW] = nxt[rd_addr[i*AW +: AW]];
  end
  rf_scoreboard #(.NREG(NREG), .AW(AW), .NRD(NRD), .NWR(NWR)) u_sb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_busy(rd_busy), .wr_en(wr_en),
    .wr_addr(wr_addr), .iss_en(iss_en), .iss_addr(iss_addr), .any_busy(any_busy)
  );
endmodule

// File: tb/tb_rf_multiport.sv
// tb_rf_multiport: directed scoreboard bench for rf_multiport with two read and two write ports
module tb_rf_multiport;
  localparam int DW = 32, NREG = 32, AW = 5, NRD = 2, NWR = 2;
  logic clk = 0, rst = 0;
  logic [NRD*AW-1:0] rd_addr = '0;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0] rd_busy;
  logic [NWR-1:0] wr_en = '0;
  logic [NWR*AW-1:0] wr_addr = '0;
  logic [NWR*DW/8-1:0] wr_be = '0;
  logic [NWR*DW-1:0] wr_data = '0;
  logic iss_en = 0;
  logic [AW-1:0] iss_addr = '0;
  logic any_busy;
  int checks = 0, errors = 0;
  typedef struct { string tag; int kind; int idx; logic [31:0] val; } exp_t;
  exp_t q[$];
  rf_multiport #(.DW(DW), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .any_busy(any_busy)
  );
  always #5 clk = ~clk;
  task automatic push(input string t, input int k, input int i, input logic [31:0] v);
    q.push_back('{t, k, i, v});
  endtask
  task automatic check_all();
    exp_t e;
    logic [31:0] o;
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      o = e.kind == 0 ? rd_data[e.idx*DW +: DW] : e.kind == 1 ? 32'(rd_busy[e.idx]) : 32'(any_busy);
      checks++;
      assert (o === e.val) else begin
        errors++;
        $error("FAIL %s observed %h expected %h", e.tag, o, e.val);
      end
    end
  endtask
  task automatic idle();
    @(negedge clk);
    rst = 0; wr_en = '0; wr_be = '0; iss_en = 0; iss_addr = '0;
  endtask
  task automatic wr(input int p, input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = a;
    wr_be[p*4 +: 4] = be;
    wr_data[p*DW +: DW] = d;
  endtask
  task automatic rda(input int i, input logic [AW-1:0] a);
    rd_addr[i*AW +: AW] = a;
  endtask
  initial begin
    // 1: random activity, then a reset cycle carrying a write and an issue
    for (int c = 0; c < 4; c++) begin
      idle();
      wr(0, AW'($urandom_range(1, 31)), 4'hF, $urandom);
      iss_en = 1; iss_addr = AW'($urandom_range(1, 31));
    end
    idle();
    rst = 1; wr(0, 5'd5, 4'hF, 32'h12345678); iss_en = 1; iss_addr = 5'd9;
    idle();
    rda(0, 5'd5); rda(1, 5'd9);
    push("rst_rd0", 0, 0, 0); push("rst_rd1", 0, 1, 0);
    push("rst_busy0", 1, 0, 0); push("rst_busy1", 1, 1, 0); push("rst_any", 2, 0, 0);
    check_all();
    // 2: full write with same-cycle bypass
    idle();
    wr(0, 5'd5, 4'hF, 32'hDEADBEEF); rda(0, 5'd5);
    push("byp_full", 0, 0, 32'hDEADBEEF); check_all();
    idle();
    push("held_full", 0, 0, 32'hDEADBEEF); check_all();
    // 3: partial byte write
    idle();
    wr(0, 5'd5, 4'b0101, 32'h11223344);
    push("byp_part", 0, 0, 32'hDE22BE44); check_all();
    idle();
    push("held_part", 0, 0, 32'hDE22BE44); check_all();
    // zero byte enables returns stored value
    idle();
    wr(0, 5'd5, 4'b0000, 32'hFFFFFFFF);
    push("be0_byp", 0, 0, 32'hDE22BE44); check_all();
    // 4: register zero stays zero and cannot go busy
    idle();
    wr(0, 5'd0, 4'hF, 32'hFFFFFFFF); iss_en = 1; iss_addr = 5'd0; rda(0, 5'd0);
    push("r0_byp", 0, 0, 0); push("r0_busy", 1, 0, 0); push("r0_any", 2, 0, 0); check_all();
    idle();
    push("r0_held", 0, 0, 0); push("r0_busy_n", 1, 0, 0); push("r0_any_n", 2, 0, 0); check_all();
    // 5: two ports on the same register, port 1 wins on overlap
    idle();
    wr(0, 5'd7, 4'hF, 32'hAAAAAAAA); wr(1, 5'd7, 4'b0011, 32'h55555555); rda(1, 5'd7);
    push("dual_byp", 0, 1, 32'hAAAA5555); check_all();
    idle();
    push("dual_held", 0, 1, 32'hAAAA5555); check_all();
    // two ports on different registers
    idle();
    wr(0, 5'd3, 4'hF, 32'h01020304); wr(1, 5'd4, 4'b1000, 32'hF0000000); rda(0, 5'd3); rda(1, 5'd4);
    push("split_p0", 0, 0, 32'h01020304); push("split_p1", 0, 1, 32'hF0000000); check_all();
    // 6: scoreboard set, set-wins, clear
    idle();
    iss_en = 1; iss_addr = 5'd9; rda(1, 5'd9);
    push("iss_nobyp", 1, 1, 0); push("iss_any_nobyp", 2, 0, 0); check_all();
    idle();
    iss_en = 1; iss_addr = 5'd9; wr(0, 5'd9, 4'hF, 32'h00000099);
    push("busy_set", 1, 1, 1); push("any_set", 2, 0, 1); check_all();
    idle();
    wr(0, 5'd9, 4'b0000, 32'h0);
    push("set_wins", 1, 1, 1); push("r9_data", 0, 1, 32'h00000099); check_all();
    idle();
    push("busy_clr", 1, 1, 0); push("any_clr", 2, 0, 0); check_all();
    // write to a non-busy register keeps it clear
    idle();
    wr(1, 5'd9, 4'hF, 32'h1);
    idle();
    push("nonbusy_wr", 1, 1, 0); push("nonbusy_data", 0, 1, 1); check_all();
    // reset mid-operation drops pending busy and the write of that cycle
    idle();
    iss_en = 1; iss_addr = 5'd12; rda(0, 5'd12);
    idle();
    push("mid_busy", 1, 0, 1); check_all();
    rst = 1; wr(0, 5'd12, 4'hF, 32'hCAFEF00D);
    idle();
    push("mid_rst_busy", 1, 0, 0); push("mid_rst_data", 0, 0, 0); push("mid_rst_any", 2, 0, 0);
    check_all();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
